// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states and
// the misalignment rule used by the trap build.
package mau_pkg;

  localparam logic [1:0] MAU_SZ_BYTE = 2'b00;
  localparam logic [1:0] MAU_SZ_HALF = 2'b01;
  localparam logic [1:0] MAU_SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } mau_state_t;

  // Size is expected already normalised (reserved 2'b11 mapped to word).
  function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      MAU_SZ_BYTE: mis = 1'b0;
      MAU_SZ_HALF: mis = offset[0];
      default:     mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mau_byte_lane.sv
// Big-endian lane logic: extracts and extends load data, and merges store
// data into a word (a word-size merge replaces every lane).
module mau_byte_lane
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shift;
  logic [31:0] shifted;

  assign shifted = word >> shift;

  always_comb begin
    shift     = '0;
    load_data = word;
    case (size)
      MAU_SZ_BYTE: begin
        shift     = {2'd3 - offset, 3'b000};
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      MAU_SZ_HALF: begin
        shift     = {~offset[1], 4'b0000};
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shift     = '0;
        load_data = word;
      end
    endcase
  end

  // Lane gi holds bits [8*gi+7:8*gi], i.e. byte offset 3-gi.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_OFS = 2'(3 - gi);
      logic       hit;
      logic [7:0] src;

      always_comb begin
        hit = 1'b0;
        src = '0;
        case (size)
          MAU_SZ_BYTE: begin
            hit = (offset == LANE_OFS);
            src = store_data[7:0];
          end
          MAU_SZ_HALF: begin
            hit = (offset[1] == LANE_OFS[1]);
            src = store_data[8*(gi%2) +: 8];
          end
          default: begin
            hit = 1'b1;
            src = store_data[8*gi +: 8];
          end
        endcase
      end

      assign merged[8*gi +: 8] = hit ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit driving a word-wide memory without byte enables (sub-word
// stores use read-modify-write). Optional macro: MAU_MISALIGN_TRAP_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  mau_state_t state_reg, state_next;

  logic              we_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic              err_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rword_reg;

  logic        accept;
  logic        trap_hit;
  logic [1:0]  size_norm;
  logic [1:0]  offset_aligned;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign size_norm = (req_size == 2'b11) ? MAU_SZ_WORD : req_size;

`ifdef MAU_MISALIGN_TRAP_EN
  assign trap_hit = mau_misaligned(size_norm, req_addr[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  // Forcing low bits is harmless in the trap build: misaligned requests never reach memory.
  always_comb begin
    offset_aligned = req_addr[1:0];
    case (size_norm)
      MAU_SZ_BYTE: offset_aligned = req_addr[1:0];
      MAU_SZ_HALF: offset_aligned = {req_addr[1], 1'b0};
      default:     offset_aligned = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      we_reg     <= 1'b0;
      size_reg   <= MAU_SZ_BYTE;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rword_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg     <= req_we;
        size_reg   <= size_norm;
        signed_reg <= req_signed;
        err_reg    <= trap_hit;
        addr_reg   <= {req_addr[ADDR_W+1:2], offset_aligned};
        wdata_reg  <= req_wdata;
      end
      // Memory samples on the falling edge inside RD, so data is stable here.
      if (state_reg == ST_RD) begin
        rword_reg <= mem_read_data;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    resp_valid   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (trap_hit)
            state_next = ST_RESP;
          else if (req_we && size_norm == MAU_SZ_WORD)
            state_next = ST_WR;
          else
            state_next = ST_RD;
        end
      end
      ST_RD: begin
        mem_read_en = 1'b1;
        state_next  = we_reg ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_write_en = 1'b1;
        state_next   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mau_byte_lane u_lane (
    .word       (rword_reg),
    .size       (size_reg),
    .offset     (addr_reg[1:0]),
    .sign_ext   (signed_reg),
    .store_data (wdata_reg),
    .load_data  (load_data),
    .merged     (merged)
  );

  assign mem_addr       = addr_reg[ADDR_W+1:2];
  assign mem_write_data = mem_write_en ? merged : '0;
  assign resp_rdata     = (resp_valid && !we_reg && !err_reg) ? load_data : '0;
  assign resp_err       = resp_valid & err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic checked against a byte-array reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Physical memory on the inverted clock (64 words are enough for the bench).
  logic [31:0] tb_mem [0:63];
  always @(negedge clk) begin
    if (mem_read_en) mem_read_data <= tb_mem[mem_addr[5:0]];
    if (mem_write_en) tb_mem[mem_addr[5:0]] = mem_write_data;
  end

  // Reference model: memory as a plain big-endian byte array.
  logic [7:0] rb [0:255];

  task automatic set_word(input int i, input logic [31:0] w);
    tb_mem[i] = w;
    rb[4*i]   = w[31:24];
    rb[4*i+1] = w[23:16];
    rb[4*i+2] = w[15:8];
    rb[4*i+3] = w[7:0];
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]};
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd1) return a[0];
    if (size >= 2'd2) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_eff_addr(input logic [1:0] size, input logic [31:0] a);
    logic [31:0] e;
    e = a;
    if (size == 2'd1) e[0] = 1'b0;
    else if (size >= 2'd2) e[1:0] = 2'b00;
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [31:0] a);
    int b;
    int x;
    b = int'(ref_eff_addr(size, a) & 32'hFF);
    if (size == 2'd0) begin
      x = int'(rb[b]);
      if (sgn && x >= 128) x = x - 256;
      return 32'(x);
    end else if (size == 2'd1) begin
      x = int'(rb[b]) * 256 + int'(rb[b+1]);
      if (sgn && x >= 32768) x = x - 65536;
      return 32'(x);
    end
    return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = int'(ref_eff_addr(size, a) & 32'hFF);
    if (size == 2'd0) begin
      rb[b] = wd[7:0];
    end else if (size == 2'd1) begin
      rb[b]   = wd[15:8];
      rb[b+1] = wd[7:0];
    end else begin
      rb[b]   = wd[31:24];
      rb[b+1] = wd[23:16];
      rb[b+2] = wd[15:8];
      rb[b+3] = wd[7:0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic trap_expected(input logic [1:0] size, input logic [31:0] a);
`ifdef MAU_MISALIGN_TRAP_EN
    return ref_misaligned(size, a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    logic        trap;
    logic        is_word;
    int          exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_rdata, ea;
    logic [15:0] exp_maddr;
    int          lat, rd, wr, both, rdy_hi, bad_addr;

    trap      = trap_expected(size, addr);
    is_word   = (size >= 2'd2);
    exp_lat   = trap ? 1 : ((!we || is_word) ? 2 : 3);
    exp_rd    = trap ? 0 : ((we && is_word) ? 0 : 1);
    exp_wr    = (trap || !we) ? 0 : 1;
    exp_rdata = (trap || we) ? 32'h0 : ref_load(size, sgn, addr);
    ea        = ref_eff_addr(size, addr);
    exp_maddr = ea[17:2];

    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1'b1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    lat = 0; rd = 0; wr = 0; both = 0; rdy_hi = 0; bad_addr = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read_en) rd++;
      if (mem_write_en) wr++;
      if (mem_read_en && mem_write_en) both++;
      if (req_ready) rdy_hi++;
      if ((mem_read_en || mem_write_en) && mem_addr !== exp_maddr) bad_addr++;
    end while (!resp_valid && lat < 8);

    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, resp_err, trap);
    chk({tag, "_rd_cycles"}, rd, exp_rd);
    chk({tag, "_wr_cycles"}, wr, exp_wr);
    chk({tag, "_en_overlap"}, both, 0);
    chk({tag, "_ready_busy"}, rdy_hi, 0);
    chk({tag, "_mem_addr"}, bad_addr, 0);
    $display("txn %0s we=%0d size=%0d sgn=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             tag, we, size, sgn, addr, wd, resp_rdata, resp_err, lat);
    if (!trap && we) ref_store(size, addr, wd);
  endtask

  initial begin
    int          cnt_resp, cnt_wr;
    logic [1:0]  bsz [0:2];
    logic        bsg [0:2];
    logic [31:0] bad [0:2];
    logic [31:0] bexp [0:2];
    int          acc [0:2];
    int          nacc, idx, resp_cnt, both, rdy_bad;
    logic        pending;
    logic        we;
    logic [1:0]  sz;

    for (int i = 0; i < 64; i++) set_word(i, $urandom);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_read_en", mem_read_en, 1'b0);
    chk("rst_mem_write_en", mem_write_en, 1'b0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store then load.
    do_req("st_word_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("mem4_after_store", tb_mem[4], 32'hDEADBEEF);
    do_req("ld_word_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Signed / unsigned byte loads.
    set_word(4, 32'h1280FF7F);
    do_req("ld_sbyte_11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    do_req("ld_ubyte_11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    do_req("ld_sbyte_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req("ld_shalf_10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);

    // Sub-word read-modify-write stores.
    set_word(5, 32'h11223344);
    do_req("st_byte_16", 1'b1, 2'd0, 1'b0, 32'h16, 32'h000000AA);
    chk("mem5_after_byte", tb_mem[5], 32'h1122AA44);
    do_req("st_half_14", 1'b1, 2'd1, 1'b0, 32'h14, 32'h0000BEEF);
    chk("mem5_after_half", tb_mem[5], 32'hBEEFAA44);

    // Misaligned word load.
    do_req("ld_word_13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    do_req("ld_rsvd_12", 1'b0, 2'd3, 1'b1, 32'h12, 32'h0);

    // Reset while the RMW write is on the bus.
    set_word(5, 32'h11223344);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h16; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_in_wr", mem_write_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", mem_write_en, 1'b0);
    chk("abort_rd_drop", mem_read_en, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_resp = 0; cnt_wr = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) cnt_resp++;
      if (mem_write_en) cnt_wr++;
    end
    chk("abort_no_resp", cnt_resp, 0);
    chk("abort_no_write", cnt_wr, 0);
    chk("abort_mem5", tb_mem[5], ref_word(5));
    chk("abort_ready", req_ready, 1'b1);
    $display("txn abort_st_byte_16 mem5=%h", tb_mem[5]);

    // Back-to-back loads with req_valid held high.
    for (int k = 0; k < 3; k++) begin
      bsz[k]  = 2'($urandom_range(0, 2));
      bsg[k]  = 1'($urandom);
      bad[k]  = ref_eff_addr(bsz[k], 32'($urandom_range(0, 255)));
      bexp[k] = ref_load(bsz[k], bsg[k], bad[k]);
    end
    @(negedge clk);
    idx = 0; nacc = 0; resp_cnt = 0; both = 0; rdy_bad = 0; pending = 1'b0;
    req_we = 1'b0; req_size = bsz[0]; req_signed = bsg[0]; req_addr = bad[0];
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        idx++;
        if (idx < 3) begin
          req_size = bsz[idx]; req_signed = bsg[idx]; req_addr = bad[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (mem_read_en && mem_write_en) both++;
      if ((mem_read_en || resp_valid) && req_ready) rdy_bad++;
      if (resp_valid) begin
        if (resp_cnt < 3) chk("b2b_rdata", resp_rdata, bexp[resp_cnt]);
        resp_cnt++;
      end
      if (req_valid && req_ready) begin
        if (nacc < 3) acc[nacc] = c;
        nacc++;
        pending = 1'b1;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_resps", resp_cnt, 3);
    if (nacc >= 3) begin
      chk("b2b_gap01", acc[1] - acc[0], 3);
      chk("b2b_gap12", acc[2] - acc[1], 3);
    end
    chk("b2b_overlap", both, 0);
    chk("b2b_ready_busy", rdy_bad, 0);
    $display("txn b2b_loads accepts=%0d resps=%0d", nacc, resp_cnt);

    // Random traffic; upper address bits above the memory range must wrap.
    for (int t = 0; t < 120; t++) begin
      we = 1'($urandom);
      sz = 2'($urandom);
      do_req("rnd", we, sz, 1'($urandom),
             32'($urandom_range(0, 255)) | ($urandom & 32'hFFFC_0000), $urandom);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", tb_mem[i], ref_word(i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
